// File: rtl/mpt_plb.sv
// mpt_plb: fully-associative Protection Lookaside Buffer caching MPT walk
// results (SDID, SPA tag, page size, 2-bit permission).
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   lookup_*_i               lookup request (sdid, spa, access type)
//   lookup_*_o               registered result one cycle after the request:
//                            valid, hit, cached perm, access allowed
//   update_*_i               install/refresh an entry from the MPT walker
//   flush_i, flush_sdid_*    global or per-SDID invalidation
//   occupancy_o              registered count of valid entries
module mpt_plb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PLEN        = 56,
  parameter int unsigned SDID_LEN    = 6
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               lookup_valid_i,
  input  logic [SDID_LEN-1:0]                lookup_sdid_i,
  input  logic [PLEN-1:0]                    lookup_spa_i,
  input  logic [1:0]                         lookup_access_i,
  output logic                               lookup_valid_o,
  output logic                               lookup_hit_o,
  output logic [1:0]                         lookup_perm_o,
  output logic                               lookup_allowed_o,
  input  logic                               update_valid_i,
  input  logic [SDID_LEN-1:0]                update_sdid_i,
  input  logic [PLEN-1:0]                    update_spa_i,
  input  logic [1:0]                         update_size_i,
  input  logic [1:0]                         update_perm_i,
  input  logic                               flush_i,
  input  logic                               flush_sdid_en_i,
  input  logic [SDID_LEN-1:0]                flush_sdid_i,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);

  localparam int unsigned TAG_W = PLEN - 12;
  localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);
  localparam int unsigned OCC_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [SDID_LEN-1:0]    sdid_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [1:0]             size_q [NUM_ENTRIES];
  logic [1:0]             perm_q [NUM_ENTRIES];
  logic [PTR_W-1:0]       rr_q, rr_d;

  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit;
  logic [1:0]       lk_perm;
  logic             up_match, up_free;
  logic [PTR_W-1:0] up_match_idx, up_free_idx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             lk_report;

  // Page-offset bits of the SPA carry no tag information.
  logic unused_spa_ok;
  assign unused_spa_ok = &{1'b0, lookup_spa_i[11:0], update_spa_i[11:0]};

  assign lk_tag = lookup_spa_i[PLEN-1:12];
  assign up_tag = update_spa_i[PLEN-1:12];

  // Tag bits that take part in the compare for a given page size.
  function automatic logic [TAG_W-1:0] size_mask(input logic [1:0] size);
    int unsigned lo;
    case (size)
      2'b01:   lo = 9;
      2'b10:   lo = 18;
      default: lo = 0;
    endcase
    return {TAG_W{1'b1}} << lo;
  endfunction

  function automatic logic access_ok(input logic [1:0] access, input logic [1:0] perm);
    case (access)
      2'b01:   return perm != 2'b00;
      2'b10:   return perm[1];
      2'b11:   return perm[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [OCC_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      if (v[i]) n = n + OCC_W'(1);
    return n;
  endfunction

  // Lookup: first matching entry in index order wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_perm = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!lk_hit && valid_q[i] && (sdid_q[i] == lookup_sdid_i) &&
          (((tag_q[i] ^ lk_tag) & size_mask(size_q[i])) == '0)) begin
        lk_hit  = 1'b1;
        lk_perm = perm_q[i];
      end
    end
  end

  // Update candidates: an identical existing entry, and the lowest free slot.
  always_comb begin
    up_match     = 1'b0;
    up_match_idx = '0;
    up_free      = 1'b0;
    up_free_idx  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!up_match && valid_q[i] && (sdid_q[i] == update_sdid_i) &&
          (size_q[i] == update_size_i) &&
          (((tag_q[i] ^ up_tag) & size_mask(update_size_i)) == '0)) begin
        up_match     = 1'b1;
        up_match_idx = PTR_W'(i);
      end
      if (!up_free && !valid_q[i]) begin
        up_free     = 1'b1;
        up_free_idx = PTR_W'(i);
      end
    end
  end

  // Next-state of valid bits / round-robin pointer; flush pre-empts update.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (flush_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        if (!flush_sdid_en_i || (sdid_q[i] == flush_sdid_i)) valid_d[i] = 1'b0;
    end else if (update_valid_i && (update_size_i != 2'b11)) begin
      wr_en = 1'b1;
      if (up_match) begin
        wr_idx = up_match_idx;
      end else if (up_free) begin
        wr_idx = up_free_idx;
      end else begin
        wr_idx = rr_q;
        rr_d   = (rr_q == PTR_W'(NUM_ENTRIES - 1)) ? '0 : rr_q + PTR_W'(1);
      end
      valid_d[wr_idx] = 1'b1;
    end
  end

  assign lk_report = lookup_valid_i && !flush_i && lk_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q          <= '0;
      rr_q             <= '0;
      occupancy_o      <= '0;
      lookup_valid_o   <= 1'b0;
      lookup_hit_o     <= 1'b0;
      lookup_perm_o    <= '0;
      lookup_allowed_o <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      rr_q             <= rr_d;
      occupancy_o      <= popcount(valid_d);
      lookup_valid_o   <= lookup_valid_i;
      lookup_hit_o     <= lk_report;
      lookup_perm_o    <= lk_report ? lk_perm : 2'b00;
      lookup_allowed_o <= lk_report && access_ok(lookup_access_i, lk_perm);
    end
  end

  // Payload needs no reset; an in-place refresh rewrites identical key fields.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      sdid_q[wr_idx] <= update_sdid_i;
      tag_q[wr_idx]  <= up_tag & size_mask(update_size_i);
      size_q[wr_idx] <= update_size_i;
      perm_q[wr_idx] <= update_perm_i;
    end
  end

endmodule

// File: tb/tb_mpt_plb.sv
module tb_mpt_plb;
  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned PLEN        = 56;
  localparam int unsigned SDID_LEN    = 6;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                lookup_valid_i;
  logic [SDID_LEN-1:0] lookup_sdid_i;
  logic [PLEN-1:0]     lookup_spa_i;
  logic [1:0]          lookup_access_i;
  logic                lookup_valid_o, lookup_hit_o, lookup_allowed_o;
  logic [1:0]          lookup_perm_o;
  logic                update_valid_i;
  logic [SDID_LEN-1:0] update_sdid_i;
  logic [PLEN-1:0]     update_spa_i;
  logic [1:0]          update_size_i, update_perm_i;
  logic                flush_i, flush_sdid_en_i;
  logic [SDID_LEN-1:0] flush_sdid_i;
  logic [3:0]          occupancy_o;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, hit, perm[1:0], allowed}
  logic [4:0] res;
  assign res = {lookup_valid_o, lookup_hit_o, lookup_perm_o, lookup_allowed_o};

  mpt_plb #(.NUM_ENTRIES(NUM_ENTRIES), .PLEN(PLEN), .SDID_LEN(SDID_LEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_sdid_i(lookup_sdid_i),
    .lookup_spa_i(lookup_spa_i), .lookup_access_i(lookup_access_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .lookup_perm_o(lookup_perm_o), .lookup_allowed_o(lookup_allowed_o),
    .update_valid_i(update_valid_i), .update_sdid_i(update_sdid_i),
    .update_spa_i(update_spa_i), .update_size_i(update_size_i),
    .update_perm_i(update_perm_i),
    .flush_i(flush_i), .flush_sdid_en_i(flush_sdid_en_i), .flush_sdid_i(flush_sdid_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled on the falling edge
  // that follows the rising edge which consumed them.
  task automatic idle_inputs();
    lookup_valid_i = 0; lookup_sdid_i = '0; lookup_spa_i = '0; lookup_access_i = '0;
    update_valid_i = 0; update_sdid_i = '0; update_spa_i = '0;
    update_size_i = '0; update_perm_i = '0;
    flush_i = 0; flush_sdid_en_i = 0; flush_sdid_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic do_update(input logic [5:0] sdid, input logic [55:0] spa,
                           input logic [1:0] size, input logic [1:0] perm);
    update_valid_i = 1; update_sdid_i = sdid; update_spa_i = spa;
    update_size_i = size; update_perm_i = perm;
    @(negedge clk_i);
    update_valid_i = 0;
  endtask

  task automatic do_lookup(input logic [5:0] sdid, input logic [55:0] spa,
                           input logic [1:0] acc);
    lookup_valid_i = 1; lookup_sdid_i = sdid; lookup_spa_i = spa; lookup_access_i = acc;
    @(negedge clk_i);
    lookup_valid_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    n_cmp++; if (res !== 5'b0_0_00_0) begin n_err++; $display("FAIL reset_out: got %b want 00000", res); end
    do_lookup(6'd3, 56'h1000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL empty_lookup: got %b want 10000", res); end
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL empty_occ: got %0d want 0", occupancy_o); end
    @(negedge clk_i);
    n_cmp++; if (res !== 5'b0_0_00_0) begin n_err++; $display("FAIL idle_out: got %b want 00000", res); end
  endtask

  task automatic test_page_1g();
    do_update(6'd3, 56'h4000_0000, 2'b10, 2'b01);
    n_cmp++; if (occupancy_o !== 4'd1) begin n_err++; $display("FAIL g1_occ: got %0d want 1", occupancy_o); end
    do_lookup(6'd3, 56'h7FFF_F123, 2'b10);
    n_cmp++; if (res !== 5'b1_1_01_0) begin n_err++; $display("FAIL g1_write: got %b want 11010", res); end
    do_lookup(6'd3, 56'h7FFF_F123, 2'b11);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL g1_exec: got %b want 11011", res); end
    do_lookup(6'd3, 56'h4000_0000, 2'b01);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL g1_read: got %b want 11011", res); end
    do_lookup(6'd3, 56'h4000_0000, 2'b00);
    n_cmp++; if (res !== 5'b1_1_01_0) begin n_err++; $display("FAIL g1_none: got %b want 11010", res); end
    do_lookup(6'd3, 56'h8000_0000, 2'b11);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL g1_above: got %b want 10000", res); end
    do_lookup(6'd4, 56'h4000_0000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL g1_other_sdid: got %b want 10000", res); end
  endtask

  task automatic test_overlap();
    do_reset();
    do_update(6'd1, 56'h20_0000, 2'b00, 2'b10);
    do_update(6'd1, 56'h20_0000, 2'b01, 2'b01);
    n_cmp++; if (occupancy_o !== 4'd2) begin n_err++; $display("FAIL ovl_occ: got %0d want 2", occupancy_o); end
    do_lookup(6'd1, 56'h20_0000, 2'b10);
    n_cmp++; if (res !== 5'b1_1_10_1) begin n_err++; $display("FAIL ovl_lowest: got %b want 11101", res); end
    do_lookup(6'd1, 56'h20_1000, 2'b10);
    n_cmp++; if (res !== 5'b1_1_01_0) begin n_err++; $display("FAIL ovl_2m: got %b want 11010", res); end
    do_lookup(6'd1, 56'h3F_F000, 2'b11);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL ovl_2m_top: got %b want 11011", res); end
    do_lookup(6'd1, 56'h40_0000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL ovl_beyond: got %b want 10000", res); end
  endtask

  task automatic test_replacement();
    do_reset();
    for (int i = 0; i < 8; i++) do_update(6'd5, 56'h1_0000 + 56'(i) * 56'h1000, 2'b00, 2'b10);
    n_cmp++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL rr_full: got %0d want 8", occupancy_o); end
    do_update(6'd5, 56'h2_0000, 2'b00, 2'b01);
    do_update(6'd5, 56'h2_1000, 2'b00, 2'b01);
    n_cmp++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL rr_occ: got %0d want 8", occupancy_o); end
    do_lookup(6'd5, 56'h1_0000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL rr_evict0: got %b want 10000", res); end
    do_lookup(6'd5, 56'h1_1000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL rr_evict1: got %b want 10000", res); end
    do_lookup(6'd5, 56'h1_2000, 2'b10);
    n_cmp++; if (res !== 5'b1_1_10_1) begin n_err++; $display("FAIL rr_keep2: got %b want 11101", res); end
    do_lookup(6'd5, 56'h2_1000, 2'b11);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL rr_new1: got %b want 11011", res); end
    do_update(6'd5, 56'h1_5000, 2'b00, 2'b11);
    n_cmp++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL ow_occ: got %0d want 8", occupancy_o); end
    do_lookup(6'd5, 56'h1_5000, 2'b11);
    n_cmp++; if (res !== 5'b1_1_11_1) begin n_err++; $display("FAIL ow_perm: got %b want 11111", res); end
    // Pointer must still be 2: next install evicts 0x12000, not 0x13000.
    do_update(6'd5, 56'h2_2000, 2'b00, 2'b01);
    do_lookup(6'd5, 56'h1_2000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL rr_evict2: got %b want 10000", res); end
    do_lookup(6'd5, 56'h1_3000, 2'b10);
    n_cmp++; if (res !== 5'b1_1_10_1) begin n_err++; $display("FAIL rr_keep3: got %b want 11101", res); end
    do_lookup(6'd5, 56'h2_2000, 2'b01);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL rr_new2: got %b want 11011", res); end
  endtask

  task automatic test_flush();
    do_reset();
    do_update(6'd1, 56'h1000, 2'b00, 2'b10);
    do_update(6'd1, 56'h2000, 2'b00, 2'b10);
    do_update(6'd2, 56'h3000, 2'b00, 2'b01);
    n_cmp++; if (occupancy_o !== 4'd3) begin n_err++; $display("FAIL fl_pre_occ: got %0d want 3", occupancy_o); end
    flush_i = 1; flush_sdid_en_i = 1; flush_sdid_i = 6'd1;
    update_valid_i = 1; update_sdid_i = 6'd1; update_spa_i = 56'h5000;
    update_size_i = 2'b00; update_perm_i = 2'b11;
    lookup_valid_i = 1; lookup_sdid_i = 6'd2; lookup_spa_i = 56'h3000; lookup_access_i = 2'b01;
    @(negedge clk_i);
    idle_inputs();
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL fl_lookup: got %b want 10000", res); end
    n_cmp++; if (occupancy_o !== 4'd1) begin n_err++; $display("FAIL fl_occ: got %0d want 1", occupancy_o); end
    do_lookup(6'd2, 56'h3000, 2'b11);
    n_cmp++; if (res !== 5'b1_1_01_1) begin n_err++; $display("FAIL fl_keep: got %b want 11011", res); end
    do_lookup(6'd1, 56'h5000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL fl_upd_drop: got %b want 10000", res); end
    do_lookup(6'd1, 56'h1000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL fl_gone: got %b want 10000", res); end
    flush_i = 1; flush_sdid_en_i = 0;
    @(negedge clk_i);
    flush_i = 0;
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL gfl_occ: got %0d want 0", occupancy_o); end
    do_lookup(6'd2, 56'h3000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL gfl_lookup: got %b want 10000", res); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_update(6'd7, 56'h9000, 2'b11, 2'b10);
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL rsv_occ: got %0d want 0", occupancy_o); end
    // Lookup concurrent with its own install sees the old contents.
    update_valid_i = 1; update_sdid_i = 6'd7; update_spa_i = 56'h9000;
    update_size_i = 2'b00; update_perm_i = 2'b10;
    lookup_valid_i = 1; lookup_sdid_i = 6'd7; lookup_spa_i = 56'h9000; lookup_access_i = 2'b10;
    @(negedge clk_i);
    update_valid_i = 0;
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL upd_lk_same: got %b want 10000", res); end
    n_cmp++; if (occupancy_o !== 4'd1) begin n_err++; $display("FAIL upd_lk_occ: got %0d want 1", occupancy_o); end
    // Lookup still asserted: next cycle hits.
    @(negedge clk_i);
    n_cmp++; if (res !== 5'b1_1_10_1) begin n_err++; $display("FAIL b2b_hit: got %b want 11101", res); end
    lookup_spa_i = 56'hA000;
    @(negedge clk_i);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL b2b_miss: got %b want 10000", res); end
    lookup_spa_i = 56'h9FFF; lookup_access_i = 2'b11;
    @(negedge clk_i);
    lookup_valid_i = 0;
    n_cmp++; if (res !== 5'b1_1_10_0) begin n_err++; $display("FAIL b2b_exec: got %b want 11100", res); end
    @(negedge clk_i);
    n_cmp++; if (res !== 5'b0_0_00_0) begin n_err++; $display("FAIL b2b_idle: got %b want 00000", res); end
  endtask

  task automatic test_reset_midop();
    do_update(6'd2, 56'hB000, 2'b00, 2'b11);
    rst_ni = 0;
    lookup_valid_i = 1; lookup_sdid_i = 6'd2; lookup_spa_i = 56'hB000; lookup_access_i = 2'b01;
    @(negedge clk_i);
    rst_ni = 1; lookup_valid_i = 0;
    n_cmp++; if (res !== 5'b0_0_00_0) begin n_err++; $display("FAIL rst_mid_out: got %b want 00000", res); end
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL rst_mid_occ: got %0d want 0", occupancy_o); end
    do_lookup(6'd2, 56'hB000, 2'b01);
    n_cmp++; if (res !== 5'b1_0_00_0) begin n_err++; $display("FAIL rst_mid_miss: got %b want 10000", res); end
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    @(negedge clk_i);
    test_reset();
    test_page_1g();
    test_overlap();
    test_replacement();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
